crossed_bus_qualifier: RTL and testbench

Downstream consumer of the 8-bit bus that has just been re-registered into the clk2 domain. The crossing is a bare two-register transfer, so the word arriving here can be torn or glitched for a cycle or more. This block accepts a new value only after it has held for STABLE_CYCLES consecutive clocks. It then queues each accepted change in a small FIFO and hands it to game logic over a valid/ready handshake.

---
 rtl/crossing_pkg.sv | 20 ++
 rtl/qual_fifo.sv | 79 +++++++
 rtl/crossed_bus_qualifier.sv | 92 +++++++++
 tb/tb_crossed_bus_qualifier.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/crossing_pkg.sv
// Shared constants and helpers for the clk2-side bus crossing and its consumers.
package crossing_pkg;

    // Bus width shared with the two-register crossing stage.
    localparam int BUS_W = 8;

    // Default number of identical consecutive samples before a value is trusted.
    localparam int STABLE_CYCLES_DEF = 3;

    // Run counter width; covers the legal STABLE_CYCLES range up to 15.
    localparam int RUN_W = 4;

    typedef logic [RUN_W-1:0] run_t;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/qual_fifo.sv
// Small synchronous FIFO with a registered head word. When the FIFO drains,
// the head register keeps the last popped value so the output is never X.
module qual_fifo
    import crossing_pkg::*;
#(
    parameter int WIDTH = BUS_W,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             push_taken,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      level_q;
    logic [WIDTH-1:0] head_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty      = (level_q == '0);
    assign full       = (level_q == (PW+1)'(DEPTH));
    assign pop_ok     = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok    = push && (!full || pop_ok);
    assign push_taken = push_ok;
    assign head_data  = head_q;
    assign level      = level_q;

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + (PW+1)'(1);
                2'b01:   level_q <= level_q - (PW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Head register: next entry after a pop, the pushed word when it becomes
    // the only entry, otherwise hold (which keeps the last popped value).
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
        end else if (pop_ok && (level_q > (PW+1)'(1))) begin
            head_q <= mem[rd_ptr + PW'(1)];
        end else if (push_ok && (empty || (pop_ok && level_q == (PW+1)'(1)))) begin
            head_q <= push_data;
        end
    end

endmodule

// File: rtl/crossed_bus_qualifier.sv
// Qualifies a bus arriving from a bare two-flop crossing: a new value is
// accepted only after it has held for STABLE_CYCLES consecutive samples, then
// queued and handed to the consumer over valid/ready.
module crossed_bus_qualifier
    import crossing_pkg::*;
#(
    parameter int WIDTH         = BUS_W,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                data_in,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                stable_value,
    output logic [ptr_w(FIFO_DEPTH):0]      fifo_level,
    output logic [7:0]                      drop_count
);

    localparam run_t RUN_MAX = run_t'(STABLE_CYCLES);

    logic [WIDTH-1:0] cand;
    run_t             run;
    logic [WIDTH-1:0] stable_q;
    logic [7:0]       drop_q;
    logic             accept;
    logic             pop;
    logic             push_taken;
    logic             fifo_full;
    logic             fifo_empty;

    // Accept once the candidate has saturated its run and differs from the
    // last accepted word; an unchanged word is never re-queued.
    assign accept = (run == RUN_MAX) && (cand != stable_q);
    assign pop    = out_valid && out_ready;

    assign out_valid    = !fifo_empty;
    assign stable_value = stable_q;
    assign drop_count   = drop_q;

    // Stability filter: count consecutive identical samples, restart on change.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand <= '0;
            run  <= '0;
        end else if (data_in == cand) begin
            if (run != RUN_MAX) begin
                run <= run + run_t'(1);
            end
        end else begin
            cand <= data_in;
            run  <= run_t'(1);
        end
    end

    // Track the most recently accepted word, even when its push is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
        end else if (accept) begin
            stable_q <= cand;
        end
    end

    // Count accepted words lost to a full FIFO, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (accept && !push_taken && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    qual_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_data  (cand),
        .pop        (pop),
        .push_taken (push_taken),
        .head_data  (out_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

endmodule

// File: tb/tb_crossed_bus_qualifier.sv
// Bench for crossed_bus_qualifier: directed table, hand sequences for the
// multi-cycle corners, then random traffic against a queue-based model.
module tb_crossed_bus_qualifier;

    localparam int S = 3;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] stable_value;
    logic [2:0] fifo_level;
    logic [7:0] drop_count;

    crossed_bus_qualifier #(
        .WIDTH         (8),
        .STABLE_CYCLES (S),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .stable_value (stable_value),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: sample history since reset, accepted-word queue.
    logic [7:0] hist[$];
    logic [7:0] q[$];
    logic [7:0] m_stable = 8'h00;
    int         m_drop = 0;
    logic [7:0] m_last = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [7:0] d, input logic rdy);
        logic       acc;
        logic [7:0] x;
        if (r) begin
            hist.delete();
            q.delete();
            m_stable = 8'h00;
            m_drop   = 0;
            m_last   = 8'h00;
            return;
        end
        acc = 1'b0;
        x   = 8'h00;
        if (hist.size() >= S) begin
            x   = hist[hist.size()-1];
            acc = (x != m_stable);
            for (int i = 0; i < S; i++)
                if (hist[hist.size()-1-i] != x) acc = 1'b0;
        end
        if (q.size() > 0 && rdy) m_last = q.pop_front();
        if (acc) begin
            m_stable = x;
            if (q.size() < D) q.push_back(x);
            else if (m_drop < 255) m_drop++;
        end
        hist.push_back(d);
        if (hist.size() > S) void'(hist.pop_front());
    endtask

    task automatic step(input logic r, input logic [7:0] d, input logic rdy);
        reset     = r;
        data_in   = d;
        out_ready = rdy;
        model_edge(r, d, rdy);
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
        chk("out_data", int'(out_data), int'((q.size() > 0) ? q[0] : m_last));
        chk("fifo_level", int'(fifo_level), q.size());
        chk("stable_value", int'(stable_value), int'(m_stable));
        chk("drop_count", int'(drop_count), m_drop);
    endtask

    typedef struct {
        logic       r;
        logic [7:0] d;
        logic       rdy;
        logic       ev;
        logic [7:0] edata;
        int         elev;
        logic [7:0] estab;
        int         edrop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [7:0] d, logic rdy, logic ev,
                                logic [7:0] edata, int elev, logic [7:0] estab, int edrop);
        vec_t v;
        v.r = r; v.d = d; v.rdy = rdy; v.ev = ev;
        v.edata = edata; v.elev = elev; v.estab = estab; v.edrop = edrop;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_seq[4];
        logic [7:0] v;
        int         hold;

        // Reset, idle zero, then 0x5A accepted three edges after first sample.
        for (int i = 0; i < 2; i++)  tbl.push_back(mk(1, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0));
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(0, 8'h5A, 1, 0, 8'h00, 0, 8'h00, 0));
        tbl.push_back(mk(0, 8'h5A, 1, 1, 8'h5A, 1, 8'h5A, 0));
        tbl.push_back(mk(0, 8'h5A, 1, 0, 8'h5A, 0, 8'h5A, 0));
        tbl.push_back(mk(0, 8'h5A, 1, 0, 8'h5A, 0, 8'h5A, 0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].d, tbl[i].rdy);
            chk("tbl_valid", int'(out_valid), int'(tbl[i].ev));
            chk("tbl_data", int'(out_data), int'(tbl[i].edata));
            chk("tbl_level", int'(fifo_level), tbl[i].elev);
            chk("tbl_stable", int'(stable_value), int'(tbl[i].estab));
            chk("tbl_drop", int'(drop_count), tbl[i].edrop);
        end

        // Glitch shorter than the stability window is ignored.
        for (int i = 0; i < 2; i++) step(0, 8'h3C, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h5A, 1);
            chk("glitch_valid", int'(out_valid), 0);
        end
        chk("glitch_stable", int'(stable_value), 8'h5A);

        // Overflow with consumer stalled: four queued, two dropped.
        for (int k = 1; k <= 6; k++)
            for (int i = 0; i < 4; i++) step(0, 8'(k), 0);
        chk("ovf_level", int'(fifo_level), 4);
        chk("ovf_drop", int'(drop_count), 2);
        chk("ovf_stable", int'(stable_value), 8'h06);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_valid", int'(out_valid), 1);
            chk("drain_data", int'(out_data), k);
            step(0, 8'h06, 1);
        end
        chk("drain_empty", int'(out_valid), 0);

        // Accept into a full FIFO on the same edge the head is popped.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) step(0, 8'h11 + 8'(k), 0);
        chk("full_level", int'(fifo_level), 4);
        for (int i = 0; i < 3; i++) step(0, 8'h77, 0);
        step(0, 8'h77, 1);
        chk("pp_level", int'(fifo_level), 4);
        chk("pp_drop", int'(drop_count), 2);
        chk("pp_stable", int'(stable_value), 8'h77);
        exp_seq = '{8'h12, 8'h13, 8'h14, 8'h77};
        for (int k = 0; k < 4; k++) begin
            chk("pp_data", int'(out_data), int'(exp_seq[k]));
            step(0, 8'h77, 1);
        end
        chk("pp_empty", int'(out_valid), 0);

        // Reset mid-operation with three queued and a partial run.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) step(0, 8'h21 + 8'(k), 0);
        chk("pre_rst_level", int'(fifo_level), 3);
        step(0, 8'h99, 0);
        step(0, 8'h99, 0);
        step(1, 8'h99, 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_stable", int'(stable_value), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h11, 1);
            chk("post_rst_wait", int'(out_valid), 0);
        end
        step(0, 8'h11, 1);
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_data", int'(out_data), 8'h11);

        // Random traffic: small value alphabet, random holds, stalls and resets.
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 4))
                0: v = 8'h00;
                1: v = 8'h5A;
                2: v = 8'hA5;
                3: v = 8'h3C;
                default: v = 8'($urandom);
            endcase
            hold = $urandom_range(1, 6);
            for (int i = 0; i < hold; i++)
                step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, v,
                     ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
